barrel_shifter_pipe: RTL
========================

BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width in bits; legal values are powers of two from 2 to 64.
REQ-002 The block SHALL define a derived constant SHW = log2(WIDTH), giving the shift-amount width and the number of pipeline stages.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the input operation is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an input this cycle.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: the operand.
REQ-008 The block SHALL have port in_shamt, input, SHW bits: the shift amount, 0 to WIDTH-1.
REQ-009 The block SHALL have port in_mode, input, 3 bits: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 pass.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream accepts the result.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: the shifted result.
REQ-013 The block SHALL have port out_zero, output, 1 bit: high when out_data == 0, qualified by out_valid.

Function
REQ-014 The datapath SHALL be SHW cascaded layers of 2:1 muxes; layer k shifts by 2^k when shamt bit k is 1, otherwise passes unchanged.
REQ-015 Each layer SHALL be followed by a register stage that holds data, valid, mode and the unconsumed shamt bits.
REQ-016 Latency from an accepted input to out_valid SHALL be exactly SHW cycles when out_ready is held high.
REQ-017 Fill rules SHALL be:
- SLL: zero-fill from the LSB side.
- SRL: zero-fill from the MSB side.
- SRA: fill with the operand's original MSB, carried through the stages.
- ROL/ROR: circular, no fill.
REQ-018 Modes 101-111 SHALL produce out_data = in_data regardless of in_shamt.
REQ-019 A shamt of 0 SHALL produce out_data = in_data in every mode.
REQ-020 A global advance signal SHALL be defined as advance = out_ready OR NOT out_valid; all stages load only when advance = 1, otherwise all stages hold.
REQ-021 in_ready SHALL equal advance, combinationally.
REQ-022 An input SHALL be accepted on a rising edge where in_valid = 1 and in_ready = 1.
REQ-023 When in_valid = 0 and the pipe advances, stage 0 SHALL load a bubble with valid = 0.
REQ-024 Bubbles SHALL propagate like data and never assert out_valid.
REQ-025 While out_valid = 1 and out_ready = 0, out_data, out_zero and out_valid SHALL remain stable.
REQ-026 No accepted operation SHALL be dropped or duplicated.
REQ-027 Throughput SHALL be one operation per cycle under a continuous in_valid = 1 and out_ready = 1.
REQ-028 Results SHALL emerge in acceptance order.

Reset
REQ-029 While rst_n = 0, all stage valid bits, out_valid and out_zero SHALL be 0, and out_data SHALL be 0.
REQ-030 Assertion of rst_n SHALL take effect asynchronously, mid-operation included; all in-flight operations are discarded.
REQ-031 in_ready SHALL read 1 during and immediately after reset.
REQ-032 The first acceptance SHALL occur on the first rising edge after rst_n deasserts.

Verification
REQ-033 Test (WIDTH=8, out_ready=1): SLL 0x81 by 1 -> 0x02 with out_valid exactly 3 cycles after acceptance.
REQ-034 Test: SRA 0x80 by 3 -> 0xF0; SRL 0x80 by 3 -> 0x10; ROR 0x01 by 1 -> 0x80; ROL 0x80 by 7 -> 0x40.
REQ-035 Test: mode 110, 0x5A by 5 -> 0x5A; SLL 0x01 by 0 -> 0x01; SRL 0x01 by 1 -> 0x00 with out_zero = 1.
REQ-036 Test: back-to-back stream of 16 random operations with out_ready low for 4 cycles mid-stream -> output held stable while stalled, all 16 results correct and in order, in_ready low only while out_valid = 1 and out_ready = 0.
REQ-037 Test: reset pulse with 3 operations in flight -> out_valid = 0 immediately; none of the 3 results appears after release.
REQ-038 Test: repeat REQ-033 through REQ-035 at WIDTH=32 (latency 5), including SRA 0x80000000 by 31 -> 0xFFFFFFFF.

Source files
------------

// File: rtl/barrel_shifter_pipe.sv
// Pipelined logarithmic barrel shifter: one 2:1 mux layer per shift-amount bit,
// each layer registered, with a single global stall (advance) for backpressure.
module barrel_shifter_pipe #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] data_q  [SHW];
  logic [WIDTH-1:0] data_d  [SHW];
  logic             valid_q [SHW];
  logic             valid_d [SHW];
  logic [2:0]       mode_q  [SHW];
  logic [2:0]       mode_d  [SHW];
  logic [SHW-1:0]   shamt_q [SHW];
  logic [SHW-1:0]   shamt_d [SHW];
  logic             msb_q   [SHW];
  logic             msb_d   [SHW];

  logic [WIDTH-1:0] src_data  [SHW];
  logic             src_valid [SHW];
  logic [2:0]       src_mode  [SHW];
  logic [SHW-1:0]   src_shamt [SHW];
  logic             src_msb   [SHW];

  logic advance;
  logic unused_bits;

  function automatic logic [WIDTH-1:0] shift_layer(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       mode,
    input logic             msb,
    input int unsigned      amt
  );
    case (mode)
      3'b000:  return d << amt;
      3'b001:  return d >> amt;
      // Fill uses the operand's original MSB carried down the pipe, since
      // the intermediate word's MSB may already have been shifted away.
      3'b010:  return (d >> amt) | (msb ? ~(ONES >> amt) : '0);
      3'b011:  return (d << amt) | (d >> (WIDTH - amt));
      3'b100:  return (d >> amt) | (d << (WIDTH - amt));
      default: return d;
    endcase
  endfunction

  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  always_comb begin
    src_data[0]  = in_data;
    src_valid[0] = in_valid;
    src_mode[0]  = in_mode;
    src_shamt[0] = in_shamt;
    src_msb[0]   = in_data[WIDTH-1];
    for (int unsigned k = 1; k < SHW; k++) begin
      src_data[k]  = data_q[k-1];
      src_valid[k] = valid_q[k-1];
      src_mode[k]  = mode_q[k-1];
      src_shamt[k] = shamt_q[k-1];
      src_msb[k]   = msb_q[k-1];
    end
    for (int unsigned k = 0; k < SHW; k++) begin
      data_d[k]  = src_shamt[k][k] ? shift_layer(src_data[k], src_mode[k], src_msb[k], 32'd1 << k)
                                   : src_data[k];
      valid_d[k] = src_valid[k];
      mode_d[k]  = src_mode[k];
      shamt_d[k] = src_shamt[k];
      msb_d[k]   = src_msb[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < SHW; k++) begin
        data_q[k]  <= '0;
        valid_q[k] <= 1'b0;
        mode_q[k]  <= '0;
        shamt_q[k] <= '0;
        msb_q[k]   <= 1'b0;
      end
    end else if (advance) begin
      for (int unsigned k = 0; k < SHW; k++) begin
        data_q[k]  <= data_d[k];
        valid_q[k] <= valid_d[k];
        mode_q[k]  <= mode_d[k];
        shamt_q[k] <= shamt_d[k];
        msb_q[k]   <= msb_d[k];
      end
    end
  end

  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_zero  = out_valid & ~|out_data;

  // Consumed shamt bits and last-stage side fields have no further reader.
  always_comb begin
    unused_bits = msb_q[SHW-1] ^ (^mode_q[SHW-1]);
    for (int unsigned k = 0; k < SHW; k++) begin
      unused_bits = unused_bits ^ (^shamt_q[k]);
    end
  end

endmodule
